fetch_unit: RTL

Instruction fetch stage placed directly upstream of the `rom` instruction memory. It owns the program counter and drives the ROM address. It registers each returned instruction together with its PC and hands the pair to decode over a valid/ready handshake. It also supports start, branch redirect with flush, and a clean stop at the end of instruction memory.

---
 rtl/fetch_unit.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage sitting directly in front of the `rom` instruction
// memory. It owns the program counter, drives the ROM address, registers each
// returned instruction together with its PC, and presents the pair to decode.
// It supports start, branch redirect with flush, and a clean stop after the
// last instruction in memory has been handed over.
//
// Handshake: a transfer happens on every rising edge where out_valid and
// out_ready are both high. While out_valid is high and out_ready is low, the
// outputs stay stable. The output register can take a new entry whenever it
// is empty or is being drained on the same edge (accept = !out_valid || out_ready).
//
// Ports:
//   clk              rising-edge clock
//   rst              asynchronous, active-high reset
//   start            begin fetching from RESET_PC (only honoured in IDLE / DONE)
//   rom_address      ROM address, combinational copy of the PC register
//   rom_instruction  ROM data for rom_address, same cycle
//   redirect_valid   taken branch/jump: flush output and reload the PC
//   redirect_target  new PC for a redirect
//   out_valid        out_instruction / out_pc are valid
//   out_ready        decode accepts the current output
//   out_instruction  registered instruction
//   out_pc           address of out_instruction
//   busy             state is RUN or DRAIN
//   done             state is DONE
//   dbg_state_o      current FSM state (IDLE=0, RUN=1, DRAIN=2, DONE=3)
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int INST_WIDTH   = 32,
  parameter int MAX_NUM_INST = 128,
  parameter int RESET_PC     = 0,
  localparam int AW          = $clog2(MAX_NUM_INST)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [AW-1:0]         rom_address,
  input  logic [INST_WIDTH-1:0] rom_instruction,
  input  logic                  redirect_valid,
  input  logic [AW-1:0]         redirect_target,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [INST_WIDTH-1:0] out_instruction,
  output logic [AW-1:0]         out_pc,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [AW-1:0] LAST_PC    = AW'(MAX_NUM_INST - 1);
  localparam logic [AW-1:0] RESET_ADDR = AW'(RESET_PC);

  state_e                  state_q, state_d;
  logic [AW-1:0]           pc_q, pc_d;
  logic                    out_valid_q, out_valid_d;
  logic [INST_WIDTH-1:0]   out_inst_q, out_inst_d;
  logic [AW-1:0]           out_pc_q, out_pc_d;

  logic accept;
  logic handshake;
  logic tgt_oob;

  assign accept    = !out_valid_q || out_ready;
  assign handshake = out_valid_q && out_ready;
  // Compared one bit wider so the check stays meaningful (and simply never
  // fires) when the depth is a power of two.
  assign tgt_oob   = ({1'b0, redirect_target} > (AW+1)'(MAX_NUM_INST - 1));

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    // A completed transfer empties the register unless a fetch refills it.
    out_valid_d = out_valid_q && !out_ready;
    out_inst_d  = out_inst_q;
    out_pc_d    = out_pc_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          pc_d    = RESET_ADDR;
        end
      end

      S_RUN, S_DRAIN: begin
        if (redirect_valid) begin
          // Redirect wins over fetch; the in-flight output is flushed.
          out_valid_d = 1'b0;
          pc_d        = redirect_target;
          state_d     = tgt_oob ? S_DONE : S_RUN;
        end else if (state_q == S_RUN) begin
          if (accept) begin
            out_valid_d = 1'b1;
            out_inst_d  = rom_instruction;
            out_pc_d    = pc_q;
            // The last address is never incremented past; drain instead.
            if (pc_q == LAST_PC) begin
              state_d = S_DRAIN;
            end else begin
              pc_d = pc_q + AW'(1);
            end
          end
        end else begin
          if (handshake) begin
            state_d = S_DONE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_ADDR;
      out_valid_q <= 1'b0;
      out_inst_q  <= '0;
      out_pc_q    <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      out_valid_q <= out_valid_d;
      out_inst_q  <= out_inst_d;
      out_pc_q    <= out_pc_d;
    end
  end

  assign rom_address     = pc_q;
  assign out_valid       = out_valid_q;
  assign out_instruction = out_inst_q;
  assign out_pc          = out_pc_q;
  assign busy            = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done            = (state_q == S_DONE);
  assign dbg_state_o     = state_q;

endmodule
